// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: sampler state encodings,
// the parity mode and the oversampling-tick divider computation.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } rx_state_e;

   typedef enum logic {
      PAR_EVEN = 1'b0,
      PAR_ODD  = 1'b1
   } parity_mode_e;

   localparam parity_mode_e PARITY_MODE = PAR_EVEN;

   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      return clk_freq / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_rx_sampler_baud_tick.sv
// Free-running down-counter divider; emits a one-cycle oversampling tick
// every DIV clocks.
module uart_baud_tick #(
   parameter int DIV = 10
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic          tick_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q  <= CW'(DIV - 1);
         tick_q <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q  <= CW'(DIV - 1);
         tick_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_q - CW'(1);
         tick_q <= 1'b0;
      end
   end

   assign o_tick = tick_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: synchronises the line, confirms start bits, shifts in
// data LSB first and checks parity/stop. UART_RX_MAJORITY_EN selects 2-of-3 voting.
//
// state  | meaning
// IDLE   | line idle, waiting for a tick that sees rx_s low
// START  | counting to mid start bit to confirm or reject it
// DATA   | sampling DATA_BITS data bits, one per OVERSAMPLE ticks
// PARITY | sampling the parity bit, updating o_parityerror
// STOP   | sampling the stop bit, then back to IDLE
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_rx,
   input  logic                 i_shift,
   input  logic                 i_resetcounter,
   input  logic                 i_outputenable,
   output logic                 o_zerodetected,
   output logic                 o_countreached,
   output logic                 o_parityerror,
   output logic                 o_onedetected,
   output logic                 o_framingerror,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int TCW = $clog2(OVERSAMPLE);
   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [TCW-1:0] TC_START_DEC = TCW'(OVERSAMPLE / 2);
`else
   localparam logic [TCW-1:0] TC_START_DEC = TCW'(OVERSAMPLE / 2 - 1);
`endif

   logic                 tick;
   logic [1:0]           sync_q;
   logic                 rx_s;
   rx_state_e            state_q;
   logic [TCW-1:0]       tc_q;
   logic [TCW-1:0]       tc_d;
   logic [BCW-1:0]       samp_cnt_q;
   logic [BCW-1:0]       bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 zd_q, cr_q, perr_q, one_q, fe_q, valid_q;
   logic                 samp_d;
   logic                 start_dec;
   logic                 bit_dec;

   uart_baud_tick #(.DIV(DIV)) u_baud_tick (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_tick  (tick)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) sync_q <= 2'b11;
      else          sync_q <= {sync_q[0], i_rx};
   end
   assign rx_s = sync_q[1];

   assign tc_d      = (tc_q == TC_LAST) ? '0 : tc_q + TCW'(1);
   assign start_dec = tick && (tc_q == TC_START_DEC);

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] maj_q;
   logic       pend_q;

   // Votes come from the two ticks before mid and the tick after it; the
   // decision lands one tick after the wrap, hence pend_q.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         maj_q  <= 2'b00;
         pend_q <= 1'b0;
      end else if (tick) begin
         pend_q <= (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP) &&
                   (tc_q == TC_LAST);
         if (state_q == S_START) begin
            if (tc_q == TCW'(OVERSAMPLE / 2 - 2)) maj_q[0] <= rx_s;
            if (tc_q == TCW'(OVERSAMPLE / 2 - 1)) maj_q[1] <= rx_s;
         end else begin
            if (tc_q == TCW'(OVERSAMPLE - 2)) maj_q[0] <= rx_s;
            if (tc_q == TC_LAST)              maj_q[1] <= rx_s;
         end
      end
   end

   assign samp_d  = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
   assign bit_dec = tick && pend_q;
`else
   assign samp_d  = rx_s;
   assign bit_dec = tick && (tc_q == TC_LAST);
`endif

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= S_IDLE;
         tc_q       <= '0;
         samp_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         zd_q       <= 1'b0;
         cr_q       <= 1'b0;
         perr_q     <= 1'b0;
         one_q      <= 1'b0;
         fe_q       <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         zd_q    <= 1'b0;
         cr_q    <= 1'b0;
         one_q   <= 1'b0;
         valid_q <= 1'b0;

         if (tick && state_q != S_IDLE) tc_q <= tc_d;

         case (state_q)
            S_IDLE: begin
               if (tick && !rx_s) begin
                  state_q <= S_START;
                  tc_q    <= '0;
               end
            end
            S_START: begin
               if (start_dec) begin
                  tc_q <= '0;
                  if (!samp_d) begin
                     zd_q       <= 1'b1;
                     perr_q     <= 1'b0;
                     fe_q       <= 1'b0;
                     samp_cnt_q <= '0;
                     state_q    <= S_DATA;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (bit_dec) begin
                  if (i_shift) begin
                     shift_q   <= {samp_d, shift_q[DATA_BITS-1:1]};
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                  end
                  if (samp_cnt_q == BCW'(DATA_BITS - 1)) begin
                     samp_cnt_q <= '0;
                     cr_q       <= 1'b1;
                     state_q    <= S_PARITY;
                  end else begin
                     samp_cnt_q <= samp_cnt_q + BCW'(1);
                  end
               end
            end
            S_PARITY: begin
               if (bit_dec) begin
                  perr_q  <= (^shift_q) ^ samp_d ^ (PARITY_MODE == PAR_ODD);
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_dec) begin
                  if (samp_d) one_q <= 1'b1;
                  else        fe_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // Counter clear wins over a same-cycle shift.
         if (i_resetcounter) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
         end

         if (i_outputenable) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
         end
      end
   end

   assign o_zerodetected = zd_q;
   assign o_countreached = cr_q;
   assign o_parityerror  = perr_q;
   assign o_onedetected  = one_q;
   assign o_framingerror = fe_q;
   assign o_data         = data_q;
   assign o_valid        = valid_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed frames, a frame-level
// event model checked every cycle, plus literal spot checks.
module tb_uart_rx_sampler;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 10_000;
   localparam int OS       = 16;
   localparam int DB       = 8;
   localparam int DIVC     = CLK_FREQ / (BAUD * OS);
   localparam int BITC     = OS * DIVC;

   logic          i_clk = 1'b0;
   logic          i_reset, i_rx, i_shift, i_resetcounter, i_outputenable;
   logic          o_zerodetected, o_countreached, o_parityerror;
   logic          o_onedetected, o_framingerror, o_valid;
   logic [DB-1:0] o_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // frame-level model
   bit            zd_armed   = 0;
   int            zd_lo, zd_hi;
   bit            frame_live = 0;
   bit            frame_done = 0;
   int            z_cyc      = 0;
   bit            exp_perr, exp_stop;
   logic [DB-1:0] exp_data;
   bit            perr_m = 0, fe_m = 0, oe_last = 0;
   logic [DB-1:0] data_m = '0;

   uart_rx_sampler #(
      .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_rx           (i_rx),
      .i_shift        (i_shift),
      .i_resetcounter (i_resetcounter),
      .i_outputenable (i_outputenable),
      .o_zerodetected (o_zerodetected),
      .o_countreached (o_countreached),
      .o_parityerror  (o_parityerror),
      .o_onedetected  (o_onedetected),
      .o_framingerror (o_framingerror),
      .o_data         (o_data),
      .o_valid        (o_valid)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({o_zerodetected, o_countreached, o_parityerror, o_onedetected,
                  o_framingerror, o_valid, o_data});
   endfunction

   // Expected frame outcome: data the shift register ends with, parity and stop bits sent.
   task automatic setup_frame(input logic [DB-1:0] shreg, input bit par, input bit stp);
      exp_data = shreg;
      exp_perr = (^shreg) ^ par;
      exp_stop = stp;
   endtask

   always @(negedge i_clk) begin
      if (!i_reset) begin
         chk("reset_outputs", all_outs(), 32'd0);
         zd_armed   = 0;
         frame_live = 0;
         perr_m     = 0;
         fe_m       = 0;
         data_m     = '0;
      end else begin
         if (o_zerodetected) begin
            chk("start_in_window", 32'(zd_armed && cyc >= zd_lo && cyc <= zd_hi), 32'd1);
            zd_armed   = 0;
            frame_live = 1;
            z_cyc      = cyc;
            perr_m     = 0;
            fe_m       = 0;
         end else if (zd_armed && cyc > zd_hi) begin
            chk("start_timeout", 32'(o_zerodetected), 32'd1);
            zd_armed = 0;
         end
         chk("countreached", 32'(o_countreached), 32'(frame_live && cyc == z_cyc + 8 * BITC));
         if (frame_live && cyc == z_cyc + 9 * BITC) perr_m = exp_perr;
         chk("parityerror", 32'(o_parityerror), 32'(perr_m));
         chk("onedetected", 32'(o_onedetected),
             32'(frame_live && cyc == z_cyc + 10 * BITC && exp_stop));
         if (frame_live && cyc == z_cyc + 10 * BITC) begin
            fe_m       = !exp_stop;
            frame_live = 0;
            frame_done = 1;
         end
         chk("framingerror", 32'(o_framingerror), 32'(fe_m));
         chk("valid", 32'(o_valid), 32'(oe_last));
         if (o_valid) data_m = exp_data;
         chk("data", 32'(o_data), 32'(data_m));
      end
      oe_last = i_outputenable;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #2;
      end
   endtask

   // Start, data LSB first, parity, stop; abort_at>0 stops driving mid-frame.
   task automatic send_frame(input logic [DB-1:0] d, input bit par, input bit stp,
                             input int abort_at);
      logic [DB+2:0] fr;
      fr         = {stp, par, d, 1'b0};
      frame_done = 0;
      zd_lo      = cyc + 6 * DIVC + 2;
      zd_hi      = cyc + 10 * DIVC + 2;
      zd_armed   = 1;
      for (int b = 0; b < DB + 3; b++) begin
         i_rx = fr[b];
         for (int k = 0; k < BITC; k++) begin
            if (abort_at > 0 && b * BITC + k == abort_at) return;
            // a low stop bit is cut short so its tail is not taken as a new start
            if (b == DB + 2 && !stp && k == 100) i_rx = 1'b1;
            idle(1);
         end
      end
      i_rx = 1'b1;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (!frame_done && n < 3000) begin
         idle(1);
         n++;
      end
      chk(nm, 32'(frame_done), 32'd1);
   endtask

   task automatic pulse_oe(input int n);
      i_outputenable = 1'b1;
      idle(n);
      i_outputenable = 1'b0;
      idle(3);
   endtask

   task automatic rc_pulse();
      int n = 0;
      while (!frame_live && n < 400) begin
         idle(1);
         n++;
      end
      chk("t5_start_seen", 32'(frame_live), 32'd1);
      n = 0;
      while (cyc < z_cyc + 4 * BITC + BITC / 2 && n < 2000) begin
         idle(1);
         n++;
      end
      i_resetcounter = 1'b1;
      idle(1);
      i_resetcounter = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      i_reset        = 1'b0;
      i_rx           = 1'b1;
      i_shift        = 1'b1;
      i_resetcounter = 1'b0;
      i_outputenable = 1'b0;
      idle(3);
      chk("reset_literal", all_outs(), 32'd0);
      i_reset = 1'b1;
      idle(30);

      // 1: clean frame
      setup_frame(8'hA5, 1'b0, 1'b1);
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      wait_done("t1_done");
      pulse_oe(1);
      chk("t1_data", 32'(o_data), 32'h0000_00A5);
      chk("t1_perr", 32'(o_parityerror), 32'd0);

      // 2: wrong parity, output enable held for three cycles
      setup_frame(8'h07, 1'b0, 1'b1);
      send_frame(8'h07, 1'b0, 1'b1, 0);
      wait_done("t2_done");
      pulse_oe(3);
      chk("t2_perr", 32'(o_parityerror), 32'd1);
      chk("t2_data", 32'(o_data), 32'h0000_0007);

      // 3: short glitch, then a good frame
      i_rx = 1'b0;
      idle(40);
      i_rx = 1'b1;
      idle(200);
      chk("t3_perr_held", 32'(o_parityerror), 32'd1);
      setup_frame(8'h3C, 1'b0, 1'b1);
      send_frame(8'h3C, 1'b0, 1'b1, 0);
      wait_done("t3_done");
      pulse_oe(1);
      chk("t3_data", 32'(o_data), 32'h0000_003C);
      chk("t3_perr", 32'(o_parityerror), 32'd0);

      // 4: stop bit low
      setup_frame(8'h55, 1'b0, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 0);
      wait_done("t4_done");
      idle(60);
      chk("t4_fe", 32'(o_framingerror), 32'd1);
      pulse_oe(1);
      chk("t4_data", 32'(o_data), 32'h0000_0055);

      // 5: counter clear after four data bits
      setup_frame(8'h5A & 8'hF0, 1'b0, 1'b1);
      fork
         send_frame(8'h5A, 1'b0, 1'b1, 0);
         rc_pulse();
      join
      wait_done("t5_done");
      pulse_oe(1);
      chk("t5_data", 32'(o_data), 32'h0000_0050);
      chk("t5_fe", 32'(o_framingerror), 32'd0);

      // 6: async reset mid-frame, then a good frame
      setup_frame(8'h3F, 1'b0, 1'b1);
      send_frame(8'h3F, 1'b0, 1'b1, 500);
      i_reset = 1'b0;
      #1;
      chk("t6_async_reset", all_outs(), 32'd0);
      i_rx = 1'b1;
      idle(3);
      i_reset = 1'b1;
      idle(50);
      setup_frame(8'h81, 1'b0, 1'b1);
      send_frame(8'h81, 1'b0, 1'b1, 0);
      wait_done("t6_done");
      pulse_oe(1);
      chk("t6_data", 32'(o_data), 32'h0000_0081);

      idle(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
